// File: rtl/alu_uart_host_pkg.sv
// Shared state encoding, byte-index constants and default widths for the
// ALU-over-UART host.
package alu_uart_host_pkg;

   localparam int unsigned DEFAULT_DATA_BITS   = 8;
   localparam int unsigned DEFAULT_OPCODE_BITS = 6;

   // Position of each request byte within the three-byte frame sequence
   localparam logic [1:0] IDX_OPE1   = 2'd0;
   localparam logic [1:0] IDX_OPE2   = 2'd1;
   localparam logic [1:0] IDX_OPCODE = 2'd2;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      LOAD        = 3'd1,
      STROBE      = 3'd2,
      WAIT_BUSY   = 3'd3,
      WAIT_FREE   = 3'd4,
      WAIT_RESULT = 3'd5
   } state_e;

endpackage

// File: rtl/timeout_counter.sv
// Result-wait counter: cleared on entry to the wait, counts while enabled and
// flags the cycle on which TIMEOUT_CYCLES-1 is reached.
module timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_expired_c = i_enable && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_uart_host.sv
// Sends ope1, ope2, opcode over a UART transmitter, then waits for a one-byte
// ALU result from the receiver or gives up after TIMEOUT_CYCLES.
module alu_uart_host
   import alu_uart_host_pkg::*;
#(
   parameter int unsigned DATA_BITS      = DEFAULT_DATA_BITS,
   parameter int unsigned OPCODE_BITS    = DEFAULT_OPCODE_BITS,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic [DATA_BITS-1:0]   i_ope1,
   input  logic [DATA_BITS-1:0]   i_ope2,
   input  logic [OPCODE_BITS-1:0] i_opcode,
   input  logic                   i_tx_available,
   output logic [DATA_BITS-1:0]   o_tx_data,
   output logic                   o_tx_start,
   input  logic [DATA_BITS-1:0]   i_rx_data,
   input  logic                   i_rx_data_ready,
   output logic [DATA_BITS-1:0]   o_result,
   output logic                   o_done,
   output logic                   o_timeout,
   output logic                   o_busy
);

   state_e                 r_state;
   logic [1:0]             r_idx;
   logic [DATA_BITS-1:0]   r_ope1;
   logic [DATA_BITS-1:0]   r_ope2;
   logic [OPCODE_BITS-1:0] r_opcode;

   logic [DATA_BITS-1:0]   w_cur_byte;
   logic                   w_cnt_clear;
   logic                   w_cnt_enable;
   logic                   w_expired;

   // Byte currently being offered to the transmitter
   always_comb begin
      w_cur_byte = r_ope1;
      case (r_idx)
         IDX_OPE2:   w_cur_byte = r_ope2;
         IDX_OPCODE: w_cur_byte = DATA_BITS'(r_opcode);
         default:    w_cur_byte = r_ope1;
      endcase
   end

   assign w_cnt_clear  = (r_state == WAIT_FREE) && i_tx_available && (r_idx == IDX_OPCODE);
   assign w_cnt_enable = (r_state == WAIT_RESULT);

   timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_clear     (w_cnt_clear),
      .i_enable    (w_cnt_enable),
      .o_expired_c (w_expired)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_idx      <= IDX_OPE1;
         r_ope1     <= '0;
         r_ope2     <= '0;
         r_opcode   <= '0;
         o_tx_data  <= '0;
         o_tx_start <= 1'b0;
         o_result   <= '0;
         o_done     <= 1'b0;
         o_timeout  <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         o_tx_start <= 1'b0;
         o_done     <= 1'b0;
         o_timeout  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_ope1   <= i_ope1;
                  r_ope2   <= i_ope2;
                  r_opcode <= i_opcode;
                  r_idx    <= IDX_OPE1;
                  o_busy   <= 1'b1;
                  r_state  <= LOAD;
               end
            end
            LOAD: begin
               o_tx_data <= w_cur_byte;
               if (i_tx_available) begin
                  o_tx_start <= 1'b1;
                  r_state    <= STROBE;
               end
            end
            STROBE: r_state <= WAIT_BUSY;
            WAIT_BUSY: begin
               if (!i_tx_available) r_state <= WAIT_FREE;
            end
            WAIT_FREE: begin
               if (i_tx_available) begin
                  if (r_idx == IDX_OPCODE) begin
                     r_state <= WAIT_RESULT;
                  end else begin
                     r_idx   <= r_idx + 2'd1;
                     r_state <= LOAD;
                  end
               end
            end
            // Received data takes priority over an expiry in the same cycle
            WAIT_RESULT: begin
               if (i_rx_data_ready) begin
                  o_result <= i_rx_data;
                  o_done   <= 1'b1;
                  o_busy   <= 1'b0;
                  r_state  <= IDLE;
               end else if (w_expired) begin
                  o_timeout <= 1'b1;
                  o_busy    <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: begin
               o_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_uart_host.sv
// Bench for alu_uart_host: a behavioural UART transmitter/receiver pair plus a
// transaction-level model of the expected bytes, result and outcome timing.
module tb_alu_uart_host;

   localparam int unsigned DW  = 8;
   localparam int unsigned OW  = 6;
   localparam int unsigned TMO = 100;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] ope1, ope2;
   logic [OW-1:0] opc;
   logic          tx_avail;
   logic [DW-1:0] tx_data;
   logic          tx_start;
   logic [DW-1:0] rx_data;
   logic          rx_ready;
   logic [DW-1:0] result;
   logic          done, timeout, busy;

   always #5 clk = ~clk;

   alu_uart_host #(
      .DATA_BITS      (DW),
      .OPCODE_BITS    (OW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clock         (clk),
      .i_reset         (rst),
      .i_start         (start),
      .i_ope1          (ope1),
      .i_ope2          (ope2),
      .i_opcode        (opc),
      .i_tx_available  (tx_avail),
      .o_tx_data       (tx_data),
      .o_tx_start      (tx_start),
      .i_rx_data       (rx_data),
      .i_rx_data_ready (rx_ready),
      .o_result        (result),
      .o_done          (done),
      .o_timeout       (timeout),
      .o_busy          (busy)
   );

   int unsigned   n_checks = 0;
   int unsigned   n_fail   = 0;
   int unsigned   cyc      = 0;
   int unsigned   n_strobe = 0, n_done = 0, n_to = 0, n_both = 0, n_wide = 0;
   int unsigned   last_done_cyc = 0, last_to_cyc = 0, mark_cyc = 0;
   int unsigned   busy_left = 0, tx_len = 10, txn_bytes = 0;
   bit            tx_block = 1'b0, mark_valid = 1'b0;
   bit            prev_start = 1'b0, prev_done = 1'b0, prev_to = 1'b0;
   logic [DW-1:0] tx_q[$];
   logic [DW-1:0] model_result = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model (busy tx_len cycles per byte) and output event monitor
   initial begin
      tx_avail = 1'b1;
      forever begin
         @(negedge clk);
         if (tx_start) begin
            tx_q.push_back(tx_data);
            n_strobe++;
            txn_bytes++;
            if (prev_start) n_wide++;
            busy_left = tx_len;
         end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0 && txn_bytes == 3) begin
               mark_cyc   = cyc;
               mark_valid = 1'b1;
            end
         end
         tx_avail = (busy_left == 0) && !tx_block;
         if (done) begin
            n_done++;
            last_done_cyc = cyc;
            if (prev_done) n_wide++;
         end
         if (timeout) begin
            n_to++;
            last_to_cyc = cyc;
            if (prev_to) n_wide++;
         end
         if (done && timeout) n_both++;
         prev_start = tx_start;
         prev_done  = done;
         prev_to    = timeout;
      end
   end

   // One transaction; k = cycle after WAIT_RESULT entry on which rx arrives (0 = never)
   task automatic run_txn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op,
                          input int unsigned len, input int unsigned k, input logic [DW-1:0] rx,
                          input int unsigned block);
      int unsigned   base_done, base_to, base_strobe, exp_cyc, waited;
      logic [DW-1:0] exp_b [3];
      logic [31:0]   got;
      bit            exp_done;
      exp_b[0] = a;
      exp_b[1] = b;
      exp_b[2] = DW'(op);
      exp_done = (k > 0);
      tx_len = len;
      tx_q.delete();
      txn_bytes  = 0;
      mark_valid = 1'b0;
      base_done  = n_done;
      base_to    = n_to;
      if (block > 0) begin
         tx_block = 1'b1;
         repeat (2) @(negedge clk);
      end
      base_strobe = n_strobe;
      ope1 = a; ope2 = b; opc = op; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ope1 = DW'($urandom); ope2 = DW'($urandom); opc = OW'($urandom);
      check_eq("busy_after_start", 32'(busy), 32'd1);
      if (block > 0) begin
         repeat (block) @(negedge clk);
         check_eq("no_strobe_while_blocked", n_strobe - base_strobe, 32'd0);
         ope1 = 8'hFF; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         tx_block = 1'b0;
      end
      waited = 0;
      while (!mark_valid && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      check_eq("three_bytes_sent", 32'(mark_valid), 32'd1);
      for (int i = 0; i < 3; i++) begin
         got = (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hDEAD_BEEF;
         check_eq($sformatf("tx_byte%0d", i), got, 32'(exp_b[i]));
      end
      if (exp_done) begin
         while (cyc < mark_cyc + k) @(negedge clk);
         rx_data = rx; rx_ready = 1'b1;
         @(negedge clk);
         rx_ready = 1'b0; rx_data = DW'($urandom);
         model_result = rx;
      end
      waited = 0;
      while (n_done == base_done && n_to == base_to && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      exp_cyc = exp_done ? mark_cyc + k + 1 : mark_cyc + TMO + 1;
      check_eq("done_count", n_done - base_done, 32'(exp_done));
      check_eq("timeout_count", n_to - base_to, 32'(!exp_done));
      check_eq("outcome_cycle", exp_done ? last_done_cyc : last_to_cyc, exp_cyc);
      check_eq("result", 32'(result), 32'(model_result));
      check_eq("busy_after_outcome", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check_eq("single_outcome", (n_done - base_done) + (n_to - base_to), 32'd1);
   endtask

   task automatic stray_rx(input logic [DW-1:0] v);
      int unsigned base_done;
      base_done = n_done;
      rx_data = v; rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("stray_result_kept", 32'(result), 32'(model_result));
      check_eq("stray_no_done", n_done - base_done, 32'd0);
   endtask

   task automatic reset_mid_send();
      int unsigned base_strobe, base_done, base_to, waited;
      tx_len = 10;
      tx_q.delete();
      txn_bytes  = 0;
      mark_valid = 1'b0;
      base_strobe = n_strobe; base_done = n_done; base_to = n_to;
      ope1 = 8'h77; ope2 = 8'h66; opc = 6'h2A; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waited = 0;
      while (n_strobe - base_strobe < 2 && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      check_eq("second_strobe_seen", n_strobe - base_strobe, 32'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_result = '0;
      check_eq("rst_mid_busy", 32'(busy), 32'd0);
      check_eq("rst_mid_tx_start", 32'(tx_start), 32'd0);
      check_eq("rst_mid_result", 32'(result), 32'd0);
      repeat (60) @(negedge clk);
      check_eq("rst_mid_no_more_strobes", n_strobe - base_strobe, 32'd2);
      check_eq("rst_mid_no_done", n_done - base_done, 32'd0);
      check_eq("rst_mid_no_timeout", n_to - base_to, 32'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] a, b;
      int unsigned   k;
      rst = 1'b1; start = 1'b0; ope1 = '0; ope2 = '0; opc = '0;
      rx_data = '0; rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_tx_data", 32'(tx_data), 32'd0);
      check_eq("reset_tx_start", 32'(tx_start), 32'd0);
      check_eq("reset_result", 32'(result), 32'd0);
      check_eq("reset_done", 32'(done), 32'd0);
      check_eq("reset_timeout", 32'(timeout), 32'd0);
      check_eq("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_txn(8'h05, 8'h03, 6'h20, 10, 5, 8'h08, 0);     // nominal
      stray_rx(8'hAA);                                  // rx in IDLE ignored
      run_txn(8'h11, 8'h22, 6'h3F, 10, 0, 8'h00, 0);     // timeout, result held
      run_txn(8'h5A, 8'hC3, 6'h15, 10, 7, 8'h99, 50);    // back-pressure + ignored start
      run_txn(8'h01, 8'h02, 6'h03, 4, TMO, 8'h3C, 0);    // rx on the expiry cycle
      reset_mid_send();
      run_txn(8'h10, 8'h20, 6'h01, 3, 1, 8'h30, 0);     // rx on first WAIT_RESULT cycle

      for (int n = 0; n < 20; n++) begin
         a = DW'($urandom);
         b = DW'($urandom);
         k = ($urandom_range(9, 0) < 7) ? $urandom_range(TMO, 1) : 0;
         run_txn(a, b, OW'($urandom), $urandom_range(12, 2), k, DW'(a + b), 0);
         if ($urandom_range(3, 0) == 0) stray_rx(DW'($urandom));
      end

      check_eq("done_and_timeout_together", n_both, 32'd0);
      check_eq("pulse_wider_than_one", n_wide, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_uart_host.md
ALU_UART_HOST -- requirements
Module: alu_uart_host

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named i_clock and i_reset.
REQ-002 Parameter DATA_BITS, default 8, SHALL set the UART byte width.
REQ-003 Parameter OPCODE_BITS, default 6, SHALL set the ALU opcode width.
REQ-004 Parameter TIMEOUT_CYCLES, default 1_000_000, SHALL set the result-wait limit in clock cycles.
REQ-005 The ports SHALL be, in this order:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_start  in  1  request pulse; operands sampled when accepted
- i_ope1  in  DATA_BITS  first operand
- i_ope2  in  DATA_BITS  second operand
- i_opcode  in  OPCODE_BITS  ALU opcode
- i_tx_available  in  1  UART transmitter idle (high = can accept byte)
- o_tx_data  out  DATA_BITS  byte to transmit
- o_tx_start  out  1  one-cycle transmit strobe
- i_rx_data  in  DATA_BITS  received byte
- i_rx_data_ready  in  1  one-cycle received-byte strobe
- o_result  out  DATA_BITS  last received result
- o_done  out  1  one-cycle pulse: result valid
- o_timeout  out  1  one-cycle pulse: no result within TIMEOUT_CYCLES
- o_busy  out  1  transaction in progress

Function
REQ-006 The block SHALL accept i_start only in IDLE, latching i_ope1, i_ope2 and i_opcode on that cycle; i_start in any other state SHALL be ignored.
REQ-007 The FSM states SHALL be IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_FREE and WAIT_RESULT.
REQ-008 The bytes SHALL be sent in the order ope1, ope2, opcode; the opcode SHALL be zero-extended to DATA_BITS.
REQ-009 LOAD SHALL drive o_tx_data with the current byte and SHALL advance to STROBE only when i_tx_available=1.
REQ-010 STROBE SHALL assert o_tx_start for exactly one cycle, keep o_tx_data stable, and go to WAIT_BUSY.
REQ-011 WAIT_BUSY SHALL wait for i_tx_available=0 and then go to WAIT_FREE.
REQ-012 WAIT_FREE SHALL wait for i_tx_available=1, then go to LOAD for the next byte, or to WAIT_RESULT after the third byte.
REQ-013 A 2-bit byte index SHALL count 0..2; it SHALL be cleared on acceptance and never wrap past 2.
REQ-014 On entry to WAIT_RESULT, a timeout counter of width clog2(TIMEOUT_CYCLES+1) SHALL be cleared and then increment every cycle.
REQ-015 In WAIT_RESULT, i_rx_data_ready=1 SHALL load o_result with i_rx_data, pulse o_done for 1 cycle on the next cycle, and return to IDLE.
REQ-016 When the counter reaches TIMEOUT_CYCLES-1 without i_rx_data_ready, the block SHALL pulse o_timeout for one cycle, keep o_result unchanged, and return to IDLE.
REQ-017 If i_rx_data_ready and counter expiry coincide, the data SHALL win: o_done pulses and o_timeout does not.
REQ-018 An i_rx_data_ready outside WAIT_RESULT SHALL be ignored, with no effect on o_result.
REQ-019 o_busy SHALL be 1 in every state except IDLE.
REQ-020 o_done and o_timeout SHALL never both be 1, and each SHALL be at most one cycle wide.

Reset
REQ-021 i_reset SHALL set the state to IDLE and clear every output, the byte index, the counter and the latched operands.
REQ-022 A reset mid-transaction SHALL abort it with no o_done or o_timeout; a UART frame already in flight is not cancelled by this block.

Structure
REQ-023 A shared package SHALL hold the FSM state encoding, the byte-index constants (IDX_OPE1=0, IDX_OPE2=1, IDX_OPCODE=2) and the default DATA_BITS and OPCODE_BITS.
REQ-024 The timeout counter SHALL be one sub-module, timeout_counter, with inputs clear and enable and a one-cycle expired output.

Verification
REQ-025 Nominal: ope1=0x05, ope2=0x03, opcode=0x20, tx model busy 10 cycles per byte, rx 0x08 returned -> three o_tx_start pulses with data 0x05, 0x03, 0x20; then o_result=0x08 and a single o_done pulse.
REQ-026 Timeout: TIMEOUT_CYCLES=100 and no rx byte -> o_timeout pulses on cycle 100 after WAIT_RESULT entry, o_result holds its prior value, o_busy falls.
REQ-027 Back-pressure and ignore: i_tx_available held 0 for 50 cycles before the first byte, and i_start re-pulsed with ope1=0xFF mid-transaction -> no strobe until available, and the original operands are sent.
REQ-028 Coincidence: i_rx_data_ready=1 with i_rx_data=0x3C on the expiry cycle -> o_done=1, o_result=0x3C, o_timeout stays 0.
REQ-029 Reset mid-send: i_reset after the second strobe -> next cycle IDLE, o_busy=0, no further strobes, no done/timeout.
REQ-030 Stray rx: i_rx_data_ready with 0xAA in IDLE -> o_result unchanged, o_done stays 0.
